instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the combinational `InstructionMemory`. It owns the program counter, drives the memory's `Address`, captures the returned `Instruction` into the IF/ID pipeline register, and applies stall, flush and control-flow redirects (`jal`/`j`, `jr`, taken `beq`) coming from the ID and EX stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0000: bubble instruction inserted into IF/ID on flush.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Stall` in 1: load-use hazard from the hazard unit; hold PC and IF/ID.
- `ID_Jump` in 1: the instruction in ID is `j`/`jal`. Target is built internally from IF/ID.
- `ID_JumpReg` in 1: the instruction in ID is `jr`. Target is `ID_JumpRegTarget`.
- `ID_JumpRegTarget` in 32: forwarded `rs` value for `jr`.
- `EX_BranchTaken` in 1: the `beq`/`bne` in EX resolved as taken.
- `EX_BranchTarget` in 32: EX-computed branch target.
- `Address` out 32: PC to the instruction memory, combinational from the PC register.
- `Instruction` in 32: instruction-memory read data for `Address`, same cycle.
- `IFID_Instruction` out 32: registered instruction presented to decode.
- `IFID_PC4` out 32: registered PC+4 of that instruction (the `jal` link value and branch base).
- `IFID_Valid` out 1: 0 while IF/ID holds a bubble.
- `FetchCount` out 32: number of instructions accepted into IF/ID since reset.

## Operation
- PC+4 is computed modulo 2^32. The PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- `Address = PC`, combinational.
- Jump target = `{IFID_PC4[31:28], IFID_Instruction[25:0], 2'b00}`.
- Redirect targets have bits [1:0] forced to 0 before loading into the PC.
- Next-PC priority, highest first:
  1. `EX_BranchTaken` selects `EX_BranchTarget`.
  2. `ID_JumpReg` selects `ID_JumpRegTarget`.
  3. `ID_Jump` selects the jump target.
  4. `Stall` holds the PC.
  5. Otherwise PC+4.
- Redirects override `Stall`.
- IF/ID update on each edge:
  - Any redirect: IF/ID gets `NOP`, `IFID_Valid=0`, `IFID_PC4=0`. The instruction being fetched is wrong-path.
  - Else `Stall`: IF/ID holds.
  - Else: IF/ID gets `{Instruction, PC+4}` with `IFID_Valid=1`, and `FetchCount` increments.
- A taken branch in EX also makes the ID instruction wrong-path. Squashing ID/EX is the hazard unit's job, not this block's.
- `ID_Jump` and `ID_JumpReg` are ignored while `IFID_Valid=0`, so a bubble can never redirect.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - PC=`RESET_PC`, so `Address=RESET_PC`.
  - `IFID_Instruction=NOP`, `IFID_PC4=0`, `IFID_Valid=0`, `FetchCount=0`.
- Reset asserted mid-operation clears all of the above immediately, regardless of pending redirects.
- Latency: the instruction at `Address` appears on `IFID_Instruction` one edge later.
- Redirect penalties:
  - Jump in ID: 1 bubble.
  - Taken branch in EX: 1 bubble in IF/ID, plus 1 squashed in ID/EX externally.
- First valid IF/ID occurs on the first edge after reset deasserts.
- Stall held N cycles: PC, IF/ID and `FetchCount` are frozen for N edges. `Address` is stable, so memory output is stable.
- Simultaneous events:
  - `EX_BranchTaken` with `ID_Jump` and `Stall`: branch target wins, IF/ID is flushed.
  - `ID_Jump` with `Stall`: the jump is taken.

## Structure
- Shared package `mips_pkg` holds: `RESET_PC` default, `NOP` encoding, opcode constants (`OP_J`=6'h02, `OP_JAL`=6'h03, `OP_BEQ`=6'h04), and the `ifid_t` struct {instruction, pc4, valid}.
- One sub-module, `pc_reg`: PC register with async active-low reset, hold enable, and load.
- Next-PC mux and IF/ID register stay in `instruction_fetch`.

## Test plan
- Reset release, no stalls → `Address` sequence is 0x0, 0x4, 0x8. `IFID_Instruction` one cycle later is 0x20040005, then 0x00001026. `FetchCount` = 2 after two edges.
- `jal` (0x0C000004) in IF/ID at PC4=0x0C with `ID_Jump=1` → next `Address`=0x10, IF/ID gets `NOP` with `IFID_Valid=0`, `FetchCount` not incremented.
- `EX_BranchTaken=1`, `EX_BranchTarget=0x0C` at the same edge as `ID_Jump=1` and `Stall=1` → `Address`=0x0C, IF/ID flushed.
- `Stall=1` for 3 cycles at PC=0x1C → `Address` stays 0x1C, IF/ID and `FetchCount` unchanged. After release, the next edge loads 0x2808_0001 (`slti`) into IF/ID.
- `ID_JumpReg=1`, `ID_JumpRegTarget`=0x0000_003B → `Address`=0x38 (low bits cleared). `ID_Jump=1` with `IFID_Valid=0` → ignored, PC+4 taken.
- `reset` pulsed low mid-cycle while `Stall=1` and PC=0x40 → `Address`=0 immediately, all outputs at reset values before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/bubble constants, opcodes, the IF/ID
// record and the PC update selector.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_HOLD = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: async active-low reset, hold, word-aligned load, and a
// free-running +4 successor that wraps modulo 2^32.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  pc_sel_e     sel,
  input  logic [31:0] load_pc,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_LOAD: pc <= align_word(load_pc);
        PC_HOLD: pc <= pc;
        default: pc <= pc4;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, drives instruction memory, and fills the IF/ID
// register under stall, flush and branch/jump redirects.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        ID_Jump,
  input  logic        ID_JumpReg,
  input  logic [31:0] ID_JumpRegTarget,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  ifid_t       ifid_q;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] redirect_pc;
  logic        redirect;
  pc_sel_e     pc_sel;

  assign jump_target = {ifid_q.pc4[31:28], ifid_q.instruction[25:0], 2'b00};

  // A bubble in ID must never redirect, so ID-stage requests are qualified
  // with IF/ID valid; the EX branch is already qualified upstream.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc4;
    pc_sel      = Stall ? PC_HOLD : PC_INC;
    if (EX_BranchTaken) begin
      redirect    = 1'b1;
      redirect_pc = EX_BranchTarget;
    end else if (ID_JumpReg && ifid_q.valid) begin
      redirect    = 1'b1;
      redirect_pc = ID_JumpRegTarget;
    end else if (ID_Jump && ifid_q.valid) begin
      redirect    = 1'b1;
      redirect_pc = jump_target;
    end
    if (redirect) begin
      pc_sel = PC_LOAD;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .sel     (pc_sel),
    .load_pc (redirect_pc),
    .pc      (pc),
    .pc4     (pc4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q     <= '{instruction: NOP, pc4: 32'd0, valid: 1'b0};
      FetchCount <= 32'd0;
    end else if (redirect) begin
      // The word being fetched this cycle is on the wrong path.
      ifid_q <= '{instruction: NOP, pc4: 32'd0, valid: 1'b0};
    end else if (!Stall) begin
      ifid_q     <= '{instruction: Instruction, pc4: pc4, valid: 1'b1};
      FetchCount <= FetchCount + 32'd1;
    end
  end

  assign Address          = pc;
  assign IFID_Instruction = ifid_q.instruction;
  assign IFID_PC4         = ifid_q.pc4;
  assign IFID_Valid       = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small instruction ROM model feeds the
// DUT while stall, flush, jump, jr, branch, wrap and reset cases are stepped.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        ID_Jump;
  logic        ID_JumpReg;
  logic [31:0] ID_JumpRegTarget;
  logic        EX_BranchTaken;
  logic [31:0] EX_BranchTarget;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PC4;
  logic        IFID_Valid;
  logic [31:0] FetchCount;

  logic [31:0] mem [64];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign Instruction = mem[Address[7:2]];

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .Stall            (Stall),
    .ID_Jump          (ID_Jump),
    .ID_JumpReg       (ID_JumpReg),
    .ID_JumpRegTarget (ID_JumpRegTarget),
    .EX_BranchTaken   (EX_BranchTaken),
    .EX_BranchTarget  (EX_BranchTarget),
    .Address          (Address),
    .Instruction      (Instruction),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PC4         (IFID_PC4),
    .IFID_Valid       (IFID_Valid),
    .FetchCount       (FetchCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic [31:0] cnt);
    check({tag, ".addr"},  Address,               addr);
    check({tag, ".instr"}, IFID_Instruction,      instr);
    check({tag, ".pc4"},   IFID_PC4,              pc4);
    check({tag, ".valid"}, {31'd0, IFID_Valid},   {31'd0, valid});
    check({tag, ".count"}, FetchCount,            cnt);
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2004_0005;
    mem[1] = 32'h0000_1026;
    mem[2] = 32'h0C00_0004;  // jal 0x10
    mem[7] = 32'h2808_0001;  // slti

    reset = 1'b0; Stall = 1'b0; ID_Jump = 1'b0; ID_JumpReg = 1'b0;
    ID_JumpRegTarget = 32'd0; EX_BranchTaken = 1'b0; EX_BranchTarget = 32'd0;

    tick(); tick();
    expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b1;

    // Sequential fetch from reset
    tick(); expect_state("seq1", 32'h04, 32'h2004_0005, 32'h04, 1'b1, 32'd1);
    tick(); expect_state("seq2", 32'h08, 32'h0000_1026, 32'h08, 1'b1, 32'd2);
    tick(); expect_state("seq3", 32'h0C, 32'h0C00_0004, 32'h0C, 1'b1, 32'd3);

    // jal in ID: target {0,0x0000004,00} = 0x10, one bubble
    ID_Jump = 1'b1;
    tick(); expect_state("jal", 32'h10, 32'h0, 32'h0, 1'b0, 32'd3);
    // Jump request against a bubble is ignored
    tick(); expect_state("jbub", 32'h14, 32'hA000_0004, 32'h14, 1'b1, 32'd4);

    // Branch beats a valid jump and a stall
    EX_BranchTaken = 1'b1; EX_BranchTarget = 32'h0C; Stall = 1'b1;
    tick(); expect_state("brpri", 32'h0C, 32'h0, 32'h0, 1'b0, 32'd4);
    EX_BranchTaken = 1'b0; ID_Jump = 1'b0; Stall = 1'b0;

    tick(); expect_state("br1", 32'h10, 32'hA000_0003, 32'h10, 1'b1, 32'd5);
    tick(); expect_state("br2", 32'h14, 32'hA000_0004, 32'h14, 1'b1, 32'd6);
    tick(); expect_state("br3", 32'h18, 32'hA000_0005, 32'h18, 1'b1, 32'd7);
    tick(); expect_state("br4", 32'h1C, 32'hA000_0006, 32'h1C, 1'b1, 32'd8);

    // Three stalled edges freeze everything
    Stall = 1'b1;
    tick(); expect_state("stall1", 32'h1C, 32'hA000_0006, 32'h1C, 1'b1, 32'd8);
    tick(); expect_state("stall2", 32'h1C, 32'hA000_0006, 32'h1C, 1'b1, 32'd8);
    tick(); expect_state("stall3", 32'h1C, 32'hA000_0006, 32'h1C, 1'b1, 32'd8);
    Stall = 1'b0;
    tick(); expect_state("unstall", 32'h20, 32'h2808_0001, 32'h20, 1'b1, 32'd9);

    // jr with misaligned target: low bits cleared
    ID_JumpReg = 1'b1; ID_JumpRegTarget = 32'h0000_003B;
    tick(); expect_state("jr", 32'h38, 32'h0, 32'h0, 1'b0, 32'd9);
    ID_JumpReg = 1'b0;
    tick(); expect_state("jr1", 32'h3C, 32'hA000_000E, 32'h3C, 1'b1, 32'd10);
    tick(); expect_state("jr2", 32'h40, 32'hA000_000F, 32'h40, 1'b1, 32'd11);

    // Asynchronous reset mid-cycle while stalled with a pending branch
    Stall = 1'b1; EX_BranchTaken = 1'b1; EX_BranchTarget = 32'h0000_0100;
    #3;
    reset = 1'b0;
    #1;
    expect_state("areset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    Stall = 1'b0; EX_BranchTaken = 1'b0;
    tick();
    expect_state("areset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b1;
    tick(); expect_state("rerun", 32'h04, 32'h2004_0005, 32'h04, 1'b1, 32'd1);

    // PC wrap: jr to top word, then +4 wraps to 0
    ID_JumpReg = 1'b1; ID_JumpRegTarget = 32'hFFFF_FFFF;
    tick(); expect_state("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd1);
    ID_JumpReg = 1'b0;
    tick(); expect_state("wrap", 32'h0, 32'hA000_003F, 32'h0, 1'b1, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
